// File: rtl/puf_challenge_driver.sv
// Challenge-side sequencer for a mux/latch arbiter PUF: LFSR challenges, race control, response packing.
// Optional PUF_MAJORITY_VOTE_EN: each challenge is raced three times and the majority bit is committed.
module puf_challenge_driver #(
    parameter int RESP_W = 8,
    parameter int SETTLE = 4
) (
    input  logic              c,
    input  logic              rn,
    input  logic              start,
    input  logic [31:0]       seed,
    output logic              busy,
    output logic [31:0]       chal,
    output logic              arb_rst,
    output logic              launch,
    input  logic              arb_q,
    output logic [RESP_W-1:0] resp,
    output logic              resp_valid,
    input  logic              resp_ready
);
    localparam int CW = $clog2(RESP_W + 1);
    localparam int SW = $clog2(SETTLE + 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_LAUNCH = 3'd2,
        ST_SETTLE = 3'd3,
        ST_SAMPLE = 3'd4,
        ST_OUT    = 3'd5
    } state_t;

    // Feedback taps for x^32+x^22+x^2+x+1; maximal length, so a nonzero state never reaches zero.
    function automatic logic lfsr_fb(input logic [31:0] v);
        return v[31] ^ v[21] ^ v[1] ^ v[0];
    endfunction

    function automatic logic maj3(input logic a, input logic b, input logic d);
        return (a & b) | (a & d) | (b & d);
    endfunction

    state_t            state_r;
    state_t            state_s;
    logic [1:0]        sync_r;
    logic [31:0]       lfsr_r;
    logic [RESP_W-1:0] resp_r;
    logic [CW-1:0]     bit_cnt_r;
    logic [SW-1:0]     settle_cnt_r;
    logic              busy_r;
    logic              arb_rst_r;
    logic              launch_r;
    logic              resp_valid_r;
    logic              busy_s;
    logic              arb_rst_s;
    logic              launch_s;
    logic              resp_valid_s;
    logic              last_eval_s;
    logic              bit_s;

`ifdef PUF_MAJORITY_VOTE_EN
    logic [1:0] vote_cnt_r;
    logic [1:0] votes_r;

    assign last_eval_s = (vote_cnt_r == 2'd2);
    assign bit_s       = maj3(votes_r[1], votes_r[0], sync_r[1]);

    // Vote bookkeeping: earlier samples of the current challenge and how many have been taken.
    always_ff @(posedge c or negedge rn) begin
        if (!rn) begin
            vote_cnt_r <= 2'd0;
            votes_r    <= 2'b00;
        end else if (state_r == ST_IDLE && start) begin
            vote_cnt_r <= 2'd0;
            votes_r    <= 2'b00;
        end else if (state_r == ST_SAMPLE) begin
            vote_cnt_r <= last_eval_s ? 2'd0 : (vote_cnt_r + 2'd1);
            votes_r    <= {votes_r[0], sync_r[1]};
        end else begin
            vote_cnt_r <= vote_cnt_r;
            votes_r    <= votes_r;
        end
    end
`else
    assign last_eval_s = 1'b1;
    assign bit_s       = maj3(sync_r[1], sync_r[1], sync_r[1]);
`endif

    // State register.
    always_ff @(posedge c or negedge rn) begin
        if (!rn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) state_s = ST_CLEAR;
                else       state_s = ST_IDLE;
            end
            ST_CLEAR:  state_s = ST_LAUNCH;
            ST_LAUNCH: state_s = ST_SETTLE;
            ST_SETTLE: begin
                if (settle_cnt_r == SW'(SETTLE - 1)) state_s = ST_SAMPLE;
                else                                 state_s = ST_SETTLE;
            end
            ST_SAMPLE: begin
                if (last_eval_s && (bit_cnt_r == CW'(RESP_W - 1))) state_s = ST_OUT;
                else                                                state_s = ST_CLEAR;
            end
            ST_OUT: begin
                if (resp_ready) state_s = ST_IDLE;
                else            state_s = ST_OUT;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Output decode from the upcoming state so the registered outputs line up with the state.
    always_comb begin
        busy_s       = (state_s != ST_IDLE);
        arb_rst_s    = (state_s == ST_IDLE) || (state_s == ST_CLEAR) || (state_s == ST_OUT);
        launch_s     = (state_s == ST_LAUNCH);
        resp_valid_s = (state_s == ST_OUT);
    end

    // Registered control outputs.
    always_ff @(posedge c or negedge rn) begin
        if (!rn) begin
            busy_r       <= 1'b0;
            arb_rst_r    <= 1'b1;
            launch_r     <= 1'b0;
            resp_valid_r <= 1'b0;
        end else begin
            busy_r       <= busy_s;
            arb_rst_r    <= arb_rst_s;
            launch_r     <= launch_s;
            resp_valid_r <= resp_valid_s;
        end
    end

    // Two-flop synchronizer for the asynchronous arbiter output.
    always_ff @(posedge c or negedge rn) begin
        if (!rn) begin
            sync_r <= 2'b00;
        end else begin
            sync_r <= {sync_r[0], arb_q};
        end
    end

    // Datapath: LFSR, response shift register, bit and settle counters.
    always_ff @(posedge c or negedge rn) begin
        if (!rn) begin
            lfsr_r       <= 32'h0000_0001;
            resp_r       <= {RESP_W{1'b0}};
            bit_cnt_r    <= CW'(0);
            settle_cnt_r <= SW'(0);
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        lfsr_r    <= (seed == 32'h0000_0000) ? 32'h0000_0001 : seed;
                        resp_r    <= {RESP_W{1'b0}};
                        bit_cnt_r <= CW'(0);
                    end
                end
                ST_LAUNCH: settle_cnt_r <= SW'(0);
                ST_SETTLE: settle_cnt_r <= settle_cnt_r + SW'(1);
                ST_SAMPLE: begin
                    if (last_eval_s) begin
                        resp_r    <= {resp_r[RESP_W-2:0], bit_s};
                        lfsr_r    <= {lfsr_r[30:0], lfsr_fb(lfsr_r)};
                        bit_cnt_r <= bit_cnt_r + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy       = busy_r;
    assign chal       = lfsr_r;
    assign arb_rst    = arb_rst_r;
    assign launch     = launch_r;
    assign resp       = resp_r;
    assign resp_valid = resp_valid_r;
endmodule

// File: tb/tb_puf_challenge_driver.sv
// Self-checking bench for puf_challenge_driver: table vectors, randomized runs, stall, abort and reset checks.
module tb_puf_challenge_driver;
`ifdef PUF_MAJORITY_VOTE_EN
    localparam int NV = 3;
`else
    localparam int NV = 1;
`endif
    localparam int EV     = 8 * NV;
    localparam int PER    = 7;
    localparam int TOTAL  = EV * PER;
    localparam logic [63:0] M_ALL  = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] M_CTRL = 64'h0000_0F00_0000_0000;

    logic        c;
    logic        rn;
    logic        start;
    logic [31:0] seed;
    logic        busy;
    logic [31:0] chal;
    logic        arb_rst;
    logic        launch;
    logic        arb_q;
    logic [7:0]  resp;
    logic        resp_valid;
    logic        resp_ready;

    int nvec;
    int nfail;

    typedef struct {
        logic [31:0] seed;
        logic [23:0] votes;
        int          ready_delay;
        logic [7:0]  exp_resp;
    } vec_t;

    vec_t tbl[4];

    puf_challenge_driver #(.RESP_W(8), .SETTLE(4)) dut (
        .c(c), .rn(rn), .start(start), .seed(seed), .busy(busy), .chal(chal),
        .arb_rst(arb_rst), .launch(launch), .arb_q(arb_q), .resp(resp),
        .resp_valid(resp_valid), .resp_ready(resp_ready)
    );

    initial c = 1'b0;
    always #5 c = ~c;

    function automatic logic [63:0] mk(input logic b, input logic a, input logic l, input logic v,
                                       input logic [7:0] r, input logic [31:0] ch);
        return {20'h0, b, a, l, v, r, ch};
    endfunction

    function automatic logic [63:0] obs();
        return mk(busy, arb_rst, launch, resp_valid, resp, chal);
    endfunction

    function automatic logic [31:0] next_lfsr(input logic [31:0] v);
        return {v[30:0], v[31] ^ v[21] ^ v[1] ^ v[0]};
    endfunction

    // Expected word: each response bit is the majority of its NV race outcomes, first bit in the MSB.
    function automatic logic [7:0] model_resp(input logic [23:0] v);
        logic [7:0] r;
        int ones;
        r = 8'h00;
        for (int b = 0; b < 8; b++) begin
            ones = 0;
            for (int k = 0; k < NV; k++) ones += int'(v[EV-1-(b*NV+k)]);
            r[7-b] = (2 * ones > NV);
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp, input logic [63:0] m);
        nvec++;
        if ((act & m) !== (exp & m)) begin
            nfail++;
            $display("FAIL %s: got %h, expected %h (mask %h) at %0t", nm, act & m, exp & m, m, $time);
        end
    endtask

    task automatic run_txn(input logic [31:0] s, input logic [23:0] v, input int rd,
                           input logic [7:0] er, input int abort_at);
        logic [31:0] lf;
        logic [7:0]  part;
        int launches;
        int ph;
        int k;
        lf = (s == 32'h0) ? 32'h1 : s;
        launches = 0;
        @(negedge c);
        chk("idle", obs(), mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 32'h0), M_CTRL);
        seed  = s;
        start = 1'b1;
        for (int n = 0; n < TOTAL; n++) begin
            @(negedge c);
            if (n == 0)  start = 1'b0;
            if (n == 10) begin start = 1'b1; seed = ~s; end
            if (n == 11) start = 1'b0;
            ph   = n % PER;
            k    = n / (PER * NV);
            part = (k == 0) ? 8'h00 : (er >> (8 - k));
            chk("eval", obs(), mk(1'b1, ph == 0, ph == 1, 1'b0, part, lf), M_ALL);
            if (launch) launches++;
            if (n == abort_at) begin
                rn = 1'b0;
                #1;
                chk("abort", obs(), mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 32'h1), M_ALL);
                @(negedge c);
                rn    = 1'b1;
                arb_q = 1'b0;
                @(negedge c);
                chk("post_abort", obs(), mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 32'h1), M_ALL);
                return;
            end
            if (ph == 0) arb_q = v[EV-1-(n/PER)];
            if (ph == 6 && ((n / PER) % NV) == NV - 1) lf = next_lfsr(lf);
        end
        @(negedge c);
        chk("valid", obs(), mk(1'b1, 1'b1, 1'b0, 1'b1, er, lf), M_ALL);
        chk("launches", 64'(launches), 64'(EV), M_ALL);
        for (int h = 0; h < rd; h++) begin
            @(negedge c);
            chk("hold", obs(), mk(1'b1, 1'b1, 1'b0, 1'b1, er, lf), M_ALL);
            if (h == 2) begin start = 1'b1; seed = 32'hDEAD_BEEF; end
            if (h == 3) start = 1'b0;
        end
        start      = 1'b0;
        resp_ready = 1'b1;
        @(negedge c);
        resp_ready = 1'b0;
        chk("done", obs(), mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 32'h0), M_CTRL);
    endtask

    initial begin
        logic [31:0] rs;
        logic [23:0] rv;
        nvec       = 0;
        nfail      = 0;
        rn         = 1'b1;
        start      = 1'b0;
        seed       = 32'h0;
        arb_q      = 1'b0;
        resp_ready = 1'b0;
`ifdef PUF_MAJORITY_VOTE_EN
        tbl[0] = '{32'h0000_0000, 24'hFF_FFFF, 0,  8'hFF};
        tbl[1] = '{32'h1234_5678, 24'hA6_9A69, 20, 8'hAA};
        tbl[2] = '{32'hFFFF_FFFF, 24'h00_0000, 3,  8'h00};
        tbl[3] = '{32'h8000_0001, 24'h1A_3EA9, 1,  8'h5A};
`else
        tbl[0] = '{32'h0000_0000, 24'h00_00FF, 0,  8'hFF};
        tbl[1] = '{32'h1234_5678, 24'h00_00B2, 20, 8'hB2};
        tbl[2] = '{32'hFFFF_FFFF, 24'h00_0000, 3,  8'h00};
        tbl[3] = '{32'h8000_0001, 24'h00_005A, 1,  8'h5A};
`endif
        #2 rn = 1'b0;
        repeat (2) @(negedge c);
        chk("in_reset", obs(), mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 32'h1), M_ALL);
        rn = 1'b1;
        @(negedge c);
        chk("after_reset", obs(), mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 32'h1), M_ALL);

        for (int i = 0; i < 4; i++)
            run_txn(tbl[i].seed, tbl[i].votes, tbl[i].ready_delay, tbl[i].exp_resp, -1);

        rs = 32'hCAFE_F00D;
        rv = 24'(EV == 8 ? 24'h0000_6D : 24'h5B_C3A7);
        run_txn(rs, rv, 0, model_resp(rv), 24);
        run_txn(rs, rv, 2, model_resp(rv), -1);

        for (int i = 0; i < 6; i++) begin
            rs = $urandom;
            rv = 24'($urandom);
            run_txn(rs, rv, $urandom_range(0, 8), model_resp(rv), -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
